// File: rtl/alu_result_buf.sv
// Registered FIFO stage after the ALU: stores result, opcode and push-time flags, and keeps result statistics.
// Latency: one cycle from push to out_valid; there is no combinational path from the inputs to out_*.
// Backpressure: in_ready depends only on occupancy and flush, so a full buffer refuses a push even during a pop.
module alu_result_buf #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [7:0]               in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_op,
    output logic [7:0]               out_y,
    output logic                     out_z,
    output logic                     out_n,
    output logic                     out_lt,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         res_cnt,
    output logic [CNT_W-1:0]         lt_cnt,
    output logic                     err_op
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] y;
        logic       z;
        logic       n;
        logic       lt;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            new_ent;
    entry_t            head;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0]  lt_cnt_q, lt_cnt_d;
    logic              err_op_q, err_op_d;
    logic              push, pop;

    assign in_ready  = rst_n & (count_q != FULL_CNT) & ~flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        new_ent.op = in_op;
        new_ent.y  = in_y;
        new_ent.z  = (in_y == 8'h00);
        new_ent.n  = in_y[7];
        new_ent.lt = (in_op == 3'b100) & in_y[7];
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        res_cnt_d = res_cnt_q;
        lt_cnt_d  = lt_cnt_q;
        err_op_d  = err_op_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
        if (push) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
            if (new_ent.lt && (lt_cnt_q != CNT_MAX)) lt_cnt_d = lt_cnt_q + CNT_W'(1);
            if (in_op[2] && (in_op[1] || in_op[0]))  err_op_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            res_cnt_q <= '0;
            lt_cnt_q  <= '0;
            err_op_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            res_cnt_q <= res_cnt_d;
            lt_cnt_q  <= lt_cnt_d;
            err_op_q  <= err_op_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (push) begin
            mem_q[wr_ptr_q] <= new_ent;
        end
    end

    // Outputs are zeroed when empty so stale storage never leaks out.
    always_comb begin
        head    = out_valid ? mem_q[rd_ptr_q] : '0;
        out_op  = head.op;
        out_y   = head.y;
        out_z   = head.z;
        out_n   = head.n;
        out_lt  = head.lt;
    end

    assign count   = count_q;
    assign res_cnt = res_cnt_q;
    assign lt_cnt  = lt_cnt_q;
    assign err_op  = err_op_q;

endmodule
